// File: rtl/muller_c_arb_ctrl_pkg.sv
// Shared types and defaults for the Muller C-element arbitration controller.
// Contents: controller state enum, default parameter values, error counter
// width and a saturating increment helper.
package muller_ctrl_pkg;

  localparam int unsigned NREQ_DEF        = 4;
  localparam int unsigned TMO_W_DEF       = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned HOLD_CYCLES_DEF = 4;
  localparam int unsigned ERR_CNT_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECHK,
    ST_RISE,
    ST_HOLD,
    ST_FALL,
    ST_DONE,
    ST_FAIL
  } state_t;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/muller_c_arb_ctrl_if.sv
// Requester / C-element bundle for muller_c_arb_ctrl.
// Signals:
//   req     requester level requests (held until ack)
//   gnt     one-hot grant, stable for a whole transaction
//   ack     one-cycle completion pulse to the grantee
//   err     valid with ack; 1 = timeout or hold failure
//   busy    controller not idle
//   c_a/c_b registered drives to the C-element inputs
//   c_q     asynchronous C-element output
//   err_cnt saturating count of failed transactions
// Modports: slave = controller side, master = requesters + element side.
interface muller_c_arb_ctrl_if #(
  parameter int unsigned NREQ = muller_ctrl_pkg::NREQ_DEF
);
  logic [NREQ-1:0]                       req;
  logic [NREQ-1:0]                       gnt;
  logic [NREQ-1:0]                       ack;
  logic                                  err;
  logic                                  busy;
  logic                                  c_a;
  logic                                  c_b;
  logic                                  c_q;
  logic [muller_ctrl_pkg::ERR_CNT_W-1:0] err_cnt;

  modport slave (
    input  req, c_q,
    output gnt, ack, err, busy, c_a, c_b, err_cnt
  );

  modport master (
    output req, c_q,
    input  gnt, ack, err, busy, c_a, c_b, err_cnt
  );
endinterface

// File: rtl/muller_c_arb_ctrl_rr_arbiter.sv
// Round-robin pick for muller_c_arb_ctrl.
// Ports:
//   clock, resetn  system clock, synchronous active-low reset
//   req            request vector
//   enable         controller can accept a new grant this cycle
//   pointer        last grantee (registered); search starts one above it
//   gnt_onehot     combinational one-hot pick (all zero when no request)
//   gnt_idx        index of the pick
module muller_rr_arbiter
  import muller_ctrl_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [NREQ-1:0]  req,
  input  logic             enable,
  output logic [IDX_W-1:0] pointer,
  output logic [NREQ-1:0]  gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic             found;
  int unsigned      idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = ptr_q;
    found      = 1'b0;
    idx        = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found           = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else if (enable && found) begin
      ptr_q <= gnt_idx;
    end
  end

  assign pointer = ptr_q;

endmodule

// File: rtl/muller_c_arb_ctrl.sv
// Shares one Muller C-element among NREQ requesters. Each grant runs one
// 4-phase exercise: check output low, drive both inputs high, wait for the
// output to rise, drive both low, wait for it to fall. Each phase wait is
// bounded by a timeout; the grantee gets an ack pulse with err on failure.
// Ports:
//   clock   system clock
//   resetn  synchronous active-low reset
//   bus     muller_c_arb_ctrl_if.slave (req/gnt/ack/err/busy/c_a/c_b/c_q/err_cnt)
// Optional feature macro: MULLER_C_HOLD_CHECK_EN adds a HOLD state between
// RISE and FALL that drives c_a=1, c_b=0 for HOLD_CYCLES cycles and requires
// the element output to stay high throughout.
module muller_c_arb_ctrl
  import muller_ctrl_pkg::*;
#(
  parameter int unsigned NREQ        = NREQ_DEF,
  parameter int unsigned TMO_W       = TMO_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic         clock,
  input  logic         resetn,
  muller_c_arb_ctrl_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(NREQ);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  // One counter serves both the phase timeout and the hold dwell.
  localparam int unsigned CNT_W  = (TMO_W > HOLD_W) ? TMO_W : HOLD_W;
  // Timeout fires on the cycle the counter would reach 2**TMO_W-1.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((2 ** TMO_W) - 2);
`ifdef MULLER_C_HOLD_CHECK_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`endif

  state_t                 state_q, state_d;
  logic [NREQ-1:0]        gnt_q, gnt_d;
  logic [NREQ-1:0]        ack_q, ack_d;
  logic                   err_q, err_d;
  logic                   ca_q, ca_d;
  logic                   cb_q, cb_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   q_s;
  logic                   fail;

  logic                   arb_en;
  logic [IDX_W-1:0]       ptr;
  logic [NREQ-1:0]        arb_onehot;
  logic [IDX_W-1:0]       arb_idx;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.c_q};
    end
  end

  assign q_s    = sync_q[SYNC_STAGES-1];
  assign arb_en = (state_q == ST_IDLE);

  muller_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clock      (clock),
    .resetn     (resetn),
    .req        (bus.req),
    .enable     (arb_en),
    .pointer    (ptr),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx)
  );

  // The arbiter pointer is loaded with the grantee on grant and holds until
  // the next grant, so it addresses ack for the whole transaction.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    err_d     = 1'b0;
    ca_d      = ca_q;
    cb_d      = cb_q;
    cnt_d     = cnt_q + 1'b1;
    err_cnt_d = err_cnt_q;
    fail      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (|arb_onehot) begin
          gnt_d          = '0;
          gnt_d[arb_idx] = 1'b1;
          state_d        = ST_PRECHK;
        end
      end
      ST_PRECHK: begin
        if (!q_s) begin
          ca_d    = 1'b1;
          cb_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_RISE;
        end else if (cnt_q == TMO_LAST) begin
          fail = 1'b1;
        end
      end
      ST_RISE: begin
        if (q_s) begin
`ifdef MULLER_C_HOLD_CHECK_EN
          cb_d    = 1'b0;
          state_d = ST_HOLD;
`else
          ca_d    = 1'b0;
          cb_d    = 1'b0;
          state_d = ST_FALL;
`endif
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          fail = 1'b1;
        end
      end
`ifdef MULLER_C_HOLD_CHECK_EN
      ST_HOLD: begin
        if (!q_s) begin
          fail = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          ca_d    = 1'b0;
          cb_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_FALL;
        end
      end
`endif
      ST_FALL: begin
        if (!q_s) begin
          ack_d[ptr] = 1'b1;
          cnt_d      = '0;
          state_d    = ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          fail = 1'b1;
        end
      end
      ST_DONE, ST_FAIL: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        ca_d    = 1'b0;
        cb_d    = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    if (fail) begin
      ca_d       = 1'b0;
      cb_d       = 1'b0;
      cnt_d      = '0;
      ack_d[ptr] = 1'b1;
      err_d      = 1'b1;
      err_cnt_d  = sat_inc(err_cnt_q);
      state_d    = ST_FAIL;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      ca_q      <= 1'b0;
      cb_q      <= 1'b0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      ca_q      <= ca_d;
      cb_q      <= cb_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.c_a     = ca_q;
  assign bus.c_b     = cb_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: doc/muller_c_arb_ctrl.md
Name: muller_c_arb_ctrl

Overview:
- Synchronous controller that shares one Muller C-element (async, 2 inputs `c_a`/`c_b`, output `c_q`) among NREQ requesters.
- Per grant it runs one full 4-phase exercise of the element: drive both inputs high, wait for `c_q` rise, drive both low, wait for `c_q` fall.
- Reports pass/timeout per transaction to the granted requester.
- Sits between the project's io_in/la pins (requesters) and the C-element macro inside muller_c_proj.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TMO_W, 8, timeout counter width; max wait per phase is 2**TMO_W-1 cycles.
- SYNC_STAGES, 2, synchronizer depth on `c_q` (2..3).
- HOLD_CYCLES, 4, hold-check dwell in cycles (used only with the optional feature).

Ports:
- clock  in  1  single system clock.
- resetn  in  1  synchronous, active-low reset.
- req  in  NREQ  per-requester level request; held until its ack.
- gnt  out  NREQ  one-hot grant; stays stable for the whole transaction.
- ack  out  NREQ  one-cycle pulse to the granted requester when its transaction ends.
- err  out  1  valid with ack; 1 = timeout or hold failure.
- busy  out  1  high in any state except IDLE.
- c_a  out  1  registered drive to C-element input A.
- c_b  out  1  registered drive to C-element input B.
- c_q  in  1  asynchronous C-element output.
- err_cnt  out  8  saturating count of failed transactions.

Behaviour:
- Reset (resetn=0 at a clock edge): state IDLE; gnt=0, ack=0, err=0, busy=0, c_a=0, c_b=0, err_cnt=0; round-robin pointer = 0; synchronizer flops cleared.
- Reset asserted mid-transaction aborts it on that edge, with no ack.
- `c_q` passes through SYNC_STAGES flops; `q_s` denotes the synchronized value. All decisions use `q_s`.
- States:
  - IDLE: if any req is set, grant via round-robin starting from the index after the last grantee. Next state PRECHK.
  - PRECHK: requires `q_s`=0.
    - If `q_s`=1, wait up to the timeout.
    - On timeout, go to FAIL.
    - If `q_s`=0, set c_a=c_b=1 and go to RISE.
  - RISE: wait for `q_s`=1, then go to FALL with c_a=c_b=0 (or to HOLD if the feature is enabled). Timeout goes to FAIL.
  - FALL: wait for `q_s`=0, then go to DONE. Timeout goes to FAIL.
  - DONE: ack[g]=1 and err=0 for one cycle; clear gnt; go to IDLE.
  - FAIL: c_a=c_b=0; ack[g]=1 and err=1 for one cycle; err_cnt += 1, saturating at 255; clear gnt; go to IDLE.
- Timeout counter:
  - Clears on every state entry and increments each cycle while waiting.
  - Timeout fires when the counter reaches 2**TMO_W-1.
- Latency, ideal element (`q_s` follows c_a/c_b after SYNC_STAGES cycles): req to gnt is 1 cycle. A passing transaction is 1 (PRECHK) + SYNC_STAGES+1 (RISE) + SYNC_STAGES+1 (FALL) + 1 (DONE) cycles.
- Arbitration:
  - The grantee's req must stay high. If it drops mid-transaction, the transaction still completes and ack is issued anyway.
  - A new grant is issued no earlier than the cycle after ack; there are no back-to-back grants in the ack cycle.
  - Simultaneous reqs: the lowest index at or after (pointer+1) mod NREQ wins.
  - The pointer updates to the grantee index on grant.
- c_a and c_b always toggle together except in the HOLD state.

Optional Feature:
- Macro: MULLER_C_HOLD_CHECK_EN.
- Defined:
  - An extra state HOLD sits between RISE and FALL.
  - HOLD drives c_a=1, c_b=0 for HOLD_CYCLES cycles.
  - `q_s` must stay 1 throughout; any 0 goes to FAIL.
  - HOLD then sets c_a=c_b=0 and goes to FALL.
  - The passing-transaction latency grows by HOLD_CYCLES.
- Undefined: HOLD state and its logic are absent; RISE goes directly to FALL.

Decomposition:
- Package muller_ctrl_pkg holds:
  - state enum (IDLE, PRECHK, RISE, HOLD, FALL, DONE, FAIL);
  - default constants for NREQ, TMO_W, SYNC_STAGES, HOLD_CYCLES;
  - ERR_CNT_W=8.
- One sub-module: muller_rr_arbiter. It is the combinational round-robin pick plus the registered pointer, with ports req, pointer, enable, gnt_onehot, gnt_idx.

Test Plan:
- Reset mid-RISE: assert resetn=0 for 1 cycle while c_a=1 -> next cycle c_a=c_b=0, gnt=0, busy=0, no ack.
- Single request with the ideal C-element model (2-cycle delay): req=4'b0010 -> gnt=0010 one cycle later; c_a/c_b rise and fall; ack[1]=1 with err=0 at cycle 1+1+3+3+1; err_cnt stays 0.
- Round-robin: req=4'b1111 held, pointer=0 -> grant order is 1, 2, 3, 0, 1, with exactly one ack per grant and no overlapping grants.
- Stuck-low element (c_q tied 0), TMO_W=4 -> RISE times out after 15 cycles; ack with err=1; c_a=c_b=0; err_cnt=1. Repeat 300 transactions -> err_cnt saturates at 255.
- Stuck-high element (c_q=1 at start) -> PRECHK times out; ack with err=1; c_a/c_b never driven high.
- With MULLER_C_HOLD_CHECK_EN defined and a faulty model (output follows A only):
  - HOLD drives c_b=0; c_q drops -> ack with err=1.
  - The correct model passes, with latency increased by HOLD_CYCLES=4.
